song_reader: RTL
================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 The block SHALL use clock clk; reset reset is synchronous and active-high.
REQ-002 Port `clk`  input  1  system clock; all state changes on its rising edge.
REQ-003 Port `reset`  input  1  synchronous, active-high reset.
REQ-004 Port `play`  input  1  level; 1 = playback enabled, 0 = stop and rewind.
REQ-005 Port `song`  input  2  song select; forms the upper address bits.
REQ-006 Port `new_note`  input  1  single-cycle request for the next note, from the control FSM.
REQ-007 Port `rom_addr`  output  7  song ROM address = {song, idx[4:0]}, driven combinationally from registered idx.
REQ-008 Port `rom_data`  input  12  ROM read data, 1-cycle registered latency: [11:6] = note code, [5:0] = duration.
REQ-009 Port `note`  output  6  registered current note code.
REQ-010 Port `duration`  output  6  registered current note duration.
REQ-011 Port `note_valid`  output  1  single-cycle pulse; note/duration updated.
REQ-012 Port `song_done`  output  1  single-cycle pulse; end of song reached.

Function
REQ-013 The block SHALL hold a 5-bit note index idx, i.e. 32 entries per song.
REQ-014 The FSM SHALL have three states:
- IDLE
- READ (address held for the ROM sample)
- LATCH (rom_data valid)
REQ-015 IDLE -> READ when new_note=1 and play=1; otherwise it stays in IDLE.
REQ-016 READ -> LATCH unconditionally; LATCH -> IDLE unconditionally.
REQ-017 The latency SHALL be fixed: new_note high in cycle N -> READ in N+1, LATCH in N+2, and note_valid/song_done pulses in N+3.
REQ-018 In LATCH with rom_data[5:0] != 0 (normal note):
- note <= rom_data[11:6], duration <= rom_data[5:0]
- note_valid = 1 in the following cycle
- idx <= idx+1
REQ-019 In LATCH with rom_data[5:0] == 0 (terminator):
- note and duration hold their values
- note_valid stays 0
- song_done = 1 in the following cycle
- idx <= 0
REQ-020 In LATCH with idx == 31 and a normal note (wrap-around):
- the note is output as in REQ-018
- idx wraps to 0
- song_done and note_valid both pulse in the same cycle
REQ-021 new_note asserted while in READ or LATCH SHALL be ignored; requests are neither queued nor counted.
REQ-022 `song` SHALL be sampled only through rom_addr; a change mid-song continues at the current idx of the new song.
REQ-023 play=0 in any state SHALL, on the next edge:
- force IDLE
- set idx <= 0, note <= 0, duration <= 0
- leave note_valid=0 and song_done=0
REQ-024 play=0 SHALL take priority over LATCH updates in the same cycle.
REQ-025 note_valid and song_done SHALL each be high for exactly one cycle per event, never longer.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL go to IDLE and clear idx, note, duration, note_valid and song_done to 0; rom_addr becomes {song, 5'd0}.
REQ-027 Reset SHALL override play and new_note, and SHALL abort any in-flight READ/LATCH without emitting pulses.

Verification
REQ-028 Basic fetch: reset, play=1, song=1, ROM[32]=12'h0C5; new_note pulse in cycle N -> rom_addr=7'd32 in N+1, note=6'h03, duration=6'h05, note_valid=1 in N+3 only, idx=1.
REQ-029 Terminator: ROM[33]=12'h0C0 at idx=1; new_note -> song_done=1 in N+3, note_valid=0, note stays 6'h03, idx=0.
REQ-030 Wrap-around: preload idx=31 with ROM[63]=12'h041; new_note -> note=6'h01, duration=6'h01, note_valid=1 and song_done=1 in the same cycle, idx=0.
REQ-031 Busy ignore: new_note in N and N+1 -> exactly one note_valid (at N+3), idx advances by 1.
REQ-032 Stop mid-fetch: play driven 0 in cycle N+2 (LATCH) -> no note_valid, note=0, duration=0, idx=0, state IDLE in N+3.
REQ-033 Reset mid-operation: reset=1 during READ -> all outputs 0 on the next cycle, no pulses, and a subsequent new_note fetches from idx 0.

Source files
------------

// File: rtl/song_reader.sv
// song_reader: steps through a 32-entry song in ROM, one note per request.
// Emits note/duration with a valid pulse; pulses song_done at end or wrap.
module song_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        new_note,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [5:0]  note,
  output logic [5:0]  duration,
  output logic        note_valid,
  output logic        song_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic [5:0]  r_note;
  logic [5:0]  r_dur;
  logic        r_nv;
  logic        r_sd;
  logic        w_term;
  logic        w_last;

  assign w_term     = (rom_data[5:0] == 6'd0);
  assign w_last     = (r_idx == 5'd31);
  assign rom_addr   = {song, r_idx};
  assign note       = r_note;
  assign duration   = r_dur;
  assign note_valid = r_nv;
  assign song_done  = r_sd;

  // Next state: one fetch walks IDLE -> READ -> LATCH -> IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (new_note && play) w_next = READ;
      READ:    w_next = LATCH;
      LATCH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; stopping playback aborts any fetch.
  always_ff @(posedge clk) begin
    if (reset || !play) r_state <= IDLE;
    else                r_state <= w_next;
  end

  // Index, note outputs and one-cycle pulses; stop rewinds and clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 5'd0;
      r_note <= 6'd0;
      r_dur  <= 6'd0;
      r_nv   <= 1'b0;
      r_sd   <= 1'b0;
    end else begin
      r_nv <= 1'b0;
      r_sd <= 1'b0;
      if (!play) begin
        r_idx  <= 5'd0;
        r_note <= 6'd0;
        r_dur  <= 6'd0;
      end else if (r_state == LATCH) begin
        if (w_term) begin
          r_sd  <= 1'b1;
          r_idx <= 5'd0;
        end else begin
          r_note <= rom_data[11:6];
          r_dur  <= rom_data[5:0];
          r_nv   <= 1'b1;
          r_sd   <= w_last;
          r_idx  <= r_idx + 5'd1;
        end
      end
    end
  end

endmodule
